scs8hd_a21oi_pipe: RTL and testbench

SCS8HD_A21OI_PIPE -- requirements
Module: scs8hd_a21oi_pipe

---
 rtl/scs8hd_a21oi_pipe.sv | 87 ++++++++
 tb/tb_scs8hd_a21oi_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_a21oi_pipe.sv
// scs8hd_a21oi_pipe: WIDTH-lane AOI21/AO21/OAI21/OA21 function block behind a
// STAGES-deep valid/ready pipeline. The function is evaluated as a transaction
// enters slot 0, so every slot only carries a WIDTH-bit result. Bubbles collapse:
// a slot refills whenever it is empty or its occupant is moving on.
module scs8hd_a21oi_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B1,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_dat [STAGES];

  logic [STAGES-1:0] w_free;
  logic [WIDTH-1:0]  w_and_or;
  logic [WIDTH-1:0]  w_or_and;
  logic [WIDTH-1:0]  w_fn;

  assign w_and_or = (A1 & A2) | B1;
  assign w_or_and = (A1 | A2) & B1;

  // Select the lane function; MODE[0]=0 selects the inverting variant.
  always_comb begin
    w_fn = '0;
    case (MODE)
      2'b00:   w_fn = ~w_and_or;
      2'b01:   w_fn = w_and_or;
      2'b10:   w_fn = ~w_or_and;
      default: w_fn = w_or_and;
    endcase
  end

  // Slot k can take new content if it, or any slot downstream of it, is empty,
  // or the output is being consumed; computed as a suffix-OR to avoid a
  // bit-to-bit feedback chain on a single vector.
  always_comb begin
    logic w_acc;
    w_free = '0;
    w_acc  = OUT_READY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_acc     = w_acc | ~r_vld[k];
      w_free[k] = w_acc;
    end
  end

  assign IN_READY  = ~RESET & w_free[0];
  assign OUT_VALID = r_vld[STAGES-1];
  assign Y         = r_dat[STAGES-1];

  // Pipeline advance; data registers only load on valid content so that
  // undriven operands offered with IN_VALID=0 never reach Y.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      if (w_free[0]) begin
        r_vld[0] <= IN_VALID;
        if (IN_VALID) begin
          r_dat[0] <= w_fn;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_free[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_dat[k] <= r_dat[k-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scs8hd_a21oi_pipe.sv
// Bench for scs8hd_a21oi_pipe: three instances (4x2, 64x4, 1x1) share stimulus.
// The reference model is a transaction queue with per-item age: the oldest item
// shows on Y once it is STAGES-1 edges old, and the block accepts whenever it
// holds fewer than STAGES items or the output is being drained.
module tb_scs8hd_a21oi_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a1, a2, b1;
  logic [1:0]  mode;
  logic        in_valid, out_ready;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [3:0]  y0;
  logic [63:0] y1;
  logic [0:0]  y2;

  scs8hd_a21oi_pipe #(.WIDTH(4), .STAGES(2)) u_def (
    .CLK(clk), .RESET(rst), .A1(a1[3:0]), .A2(a2[3:0]), .B1(b1[3:0]), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(ir0), .Y(y0), .OUT_VALID(ov0), .OUT_READY(out_ready));

  scs8hd_a21oi_pipe #(.WIDTH(64), .STAGES(4)) u_big (
    .CLK(clk), .RESET(rst), .A1(a1), .A2(a2), .B1(b1), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(ir1), .Y(y1), .OUT_VALID(ov1), .OUT_READY(out_ready));

  scs8hd_a21oi_pipe #(.WIDTH(1), .STAGES(1)) u_small (
    .CLK(clk), .RESET(rst), .A1(a1[0:0]), .A2(a2[0:0]), .B1(b1[0:0]), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(ir2), .Y(y2), .OUT_VALID(ov2), .OUT_READY(out_ready));

  logic        obs_ir [3];
  logic        obs_ov [3];
  logic [63:0] obs_y  [3];

  always_comb begin
    obs_ir[0] = ir0;  obs_ov[0] = ov0;  obs_y[0] = {60'b0, y0};
    obs_ir[1] = ir1;  obs_ov[1] = ov1;  obs_y[1] = y1;
    obs_ir[2] = ir2;  obs_ov[2] = ov2;  obs_y[2] = {63'b0, y2};
  end

  typedef struct {
    int          id;
    logic [63:0] d;
    int          age;
  } item_t;

  item_t       sb[$];
  int          stg [3] = '{2, 4, 1};
  logic [63:0] msk [3] = '{64'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
  bit          y_zero [3] = '{1'b0, 1'b0, 1'b0};
  bit          armed = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [63:0] ref_fn(logic [1:0] m, logic [63:0] x1, logic [63:0] x2,
                                         logic [63:0] x3);
    case (m)
      2'd0:    return ~((x1 & x2) | x3);
      2'd1:    return (x1 & x2) | x3;
      2'd2:    return ~((x1 | x2) & x3);
      default: return (x1 | x2) & x3;
    endcase
  endfunction

  function automatic int occ(int d);
    int n = 0;
    foreach (sb[i]) if (sb[i].id == d) n++;
    return n;
  endfunction

  function automatic int head(int d);
    foreach (sb[i]) if (sb[i].id == d) return i;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check every instance against the model, then advance it.
  task automatic step();
    bit acc [3];
    bit cons[3];
    int h;
    bit exp_ir, exp_ov;
    #1;
    for (int d = 0; d < 3; d++) begin
      h      = head(d);
      exp_ir = !rst && ((occ(d) < stg[d]) || out_ready);
      exp_ov = armed && (h >= 0) && (sb[h].age >= stg[d] - 1);
      chk($sformatf("in_ready[%0d]", d), {63'b0, obs_ir[d]}, {63'b0, exp_ir});
      if (armed) begin
        chk($sformatf("out_valid[%0d]", d), {63'b0, obs_ov[d]}, {63'b0, exp_ov});
        if (exp_ov) chk($sformatf("y[%0d]", d), obs_y[d], sb[h].d);
        else if (y_zero[d]) chk($sformatf("y_reset[%0d]", d), obs_y[d], 64'h0);
      end
      if (exp_ov) y_zero[d] = 1'b0;
      acc[d]  = in_valid && exp_ir;
      cons[d] = exp_ov && out_ready;
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      armed  = 1'b1;
      y_zero = '{1'b1, 1'b1, 1'b1};
    end else begin
      foreach (sb[i]) sb[i].age++;
      for (int d = 0; d < 3; d++) begin
        item_t it;
        if (cons[d]) sb.delete(head(d));
        if (acc[d]) begin
          it.id  = d;
          it.d   = ref_fn(mode, a1, a2, b1) & msk[d];
          it.age = 0;
          sb.push_back(it);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_data();
    a1   = {$urandom, $urandom};
    a2   = {$urandom, $urandom};
    b1   = {$urandom, $urandom};
    mode = 2'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a1 = '0; a2 = '0; b1 = '0; mode = 2'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Worked example: AOI21 of 1100/1010/0001 is 0110 one cycle after accept.
    a1 = 64'hC; a2 = 64'hA; b1 = 64'h1; mode = 2'd0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("example_y", {60'b0, y0}, 64'h6);

    // Truth table: every {A1,A2,B1} pattern in all lanes, all four modes.
    in_valid = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 8; p++) begin
        a1   = ((p >> 2) & 1) != 0 ? '1 : '0;
        a2   = ((p >> 1) & 1) != 0 ? '1 : '0;
        b1   = (p & 1) != 0 ? '1 : '0;
        mode = 2'(m);
        step();
      end
    end

    // Back-to-back random transactions.
    for (int i = 0; i < 100; i++) begin
      rand_data();
      step();
    end

    // Full stall, then a single-cycle drain.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
    end
    out_ready = 1'b1;
    rand_data();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
    end

    // Random valid/ready; operands are undriven whenever nothing is offered.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid) rand_data();
      else begin
        a1 = 'x; a2 = 'x; b1 = 'x;
      end
      step();
    end

    // Reset while full: nothing from before the reset may appear afterwards.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      rand_data();
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
